// File: rtl/orb_frame_reader.sv
// Read side of the orbital packing RAM. On a frame request, reads FRAME_LEN words from the
// page the packer is not writing and streams them out over valid/ready through a 4-deep FIFO.
module orb_frame_reader #(
   parameter int unsigned ADDR_W    = 11,
   parameter int unsigned WORD_W    = 12,
   parameter int unsigned FRAME_LEN = 2048,
   parameter int unsigned RAM_LAT   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              SW,
   input  logic [WORD_W-1:0] RdData,
   output logic              RdEn,
   output logic [ADDR_W-1:0] RdAddr,
   output logic              RdPage,
   output logic [WORD_W-1:0] oWord,
   output logic              oValid,
   input  logic              iReady,
   output logic              busy,
   output logic              frameDone,
   output logic              overrun
);

   // One extra bit so FRAME_LEN = 2**ADDR_W still has a distinct terminal count.
   localparam int unsigned CntW = ADDR_W + 1;
   localparam logic [CntW-1:0] LastIdx = CntW'(FRAME_LEN - 1);

   typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   issue_q, issue_d;
   logic [CntW-1:0]   accept_q, accept_d;
   logic              page_q, page_d;
   logic              busy_q, busy_d;
   logic              frame_done;

   logic              req_meta, req_sync, req_d;
   logic              sw_meta, sw_sync, sw_d;
   logic              req_rise, sw_edge;

   logic [RAM_LAT-1:0] rd_pipe_q;
   logic [2:0]         in_flight;
   logic [3:0]         slots_used;
   logic               rd_en, push, pop;

   logic [WORD_W-1:0] mem_q [4];
   logic [1:0]        wr_ptr_q, rd_ptr_q;
   logic [2:0]        count_q;

   // Two-flop synchronisers for the asynchronous req and SW inputs, plus edge-detect delay.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_meta <= 1'b0;
         req_sync <= 1'b0;
         req_d    <= 1'b0;
         sw_meta  <= 1'b0;
         sw_sync  <= 1'b0;
         sw_d     <= 1'b0;
      end else begin
         req_meta <= req;
         req_sync <= req_meta;
         req_d    <= req_sync;
         sw_meta  <= SW;
         sw_sync  <= sw_meta;
         sw_d     <= sw_sync;
      end
   end

   assign req_rise = req_sync & ~req_d;
   assign sw_edge  = sw_sync ^ sw_d;

   // Count reads still travelling through the RAM pipeline.
   always_comb begin
      in_flight = '0;
      for (int i = 0; i < int'(RAM_LAT); i++) begin
         in_flight = in_flight + 3'(rd_pipe_q[i]);
      end
   end

   // In-flight reads reserve FIFO space so a capture can never find the FIFO full.
   assign slots_used = {1'b0, count_q} + {1'b0, in_flight};
   assign rd_en      = (state_q == StRead) && (slots_used < 4'd4);
   assign push       = rd_pipe_q[RAM_LAT-1];
   assign oValid     = (count_q != 3'd0);
   assign pop        = oValid & iReady;

   // Frame sequencing: next state, counters, page latch and done pulse.
   always_comb begin
      state_d    = state_q;
      issue_d    = issue_q;
      accept_d   = accept_q;
      page_d     = page_q;
      busy_d     = busy_q;
      frame_done = 1'b0;
      case (state_q)
         StIdle: begin
            if (req_rise) begin
               state_d  = StRead;
               page_d   = ~sw_sync;
               issue_d  = '0;
               accept_d = '0;
               busy_d   = 1'b1;
            end
         end
         StRead: begin
            if (rd_en) begin
               issue_d = issue_q + 1'b1;
               if (issue_q == LastIdx) begin
                  state_d = StDrain;
               end
            end
            if (pop) begin
               accept_d = accept_q + 1'b1;
            end
         end
         StDrain: begin
            if (pop) begin
               accept_d = accept_q + 1'b1;
               if (accept_q == LastIdx) begin
                  state_d    = StIdle;
                  busy_d     = 1'b0;
                  frame_done = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM and frame counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         issue_q  <= '0;
         accept_q <= '0;
         page_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         issue_q  <= issue_d;
         accept_q <= accept_d;
         page_q   <= page_d;
         busy_q   <= busy_d;
      end
   end

   // Shift read enables along so capture happens RAM_LAT edges after issue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pipe_q <= '0;
      end else begin
         rd_pipe_q[0] <= rd_en;
         for (int i = 1; i < int'(RAM_LAT); i++) begin
            rd_pipe_q[i] <= rd_pipe_q[i-1];
         end
      end
   end

   // Output FIFO; a simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= RdData;
            wr_ptr_q        <= wr_ptr_q + 2'd1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 2'd1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 3'd1;
            2'b01:   count_q <= count_q - 3'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign RdEn      = rd_en;
   assign RdAddr    = issue_q[ADDR_W-1:0];
   assign RdPage    = page_q;
   assign oWord     = mem_q[rd_ptr_q];
   assign busy      = busy_q;
   assign frameDone = frame_done;
   assign overrun   = sw_edge & busy_q;

endmodule

// File: tb/tb_orb_frame_reader.sv
// Directed bench for orb_frame_reader: a full-size frame instance (RAM_LAT=1) and a
// single-word instance (RAM_LAT=2). RAM model returns {page, addr} so page and order are visible.
module tb_orb_frame_reader;

   localparam int unsigned AW = 11;
   localparam int unsigned WW = 12;
   localparam int unsigned FL = 2048;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Instance A: default frame, RAM_LAT=1
   logic          req = 1'b0, sw = 1'b0, rdy = 1'b1;
   logic [WW-1:0] rd_data, ram_q, o_word;
   logic [AW-1:0] rd_addr;
   logic          rd_en, rd_page, o_valid, busy, frame_done, overrun;

   orb_frame_reader #(.ADDR_W(AW), .WORD_W(WW), .FRAME_LEN(FL), .RAM_LAT(1)) dut (
      .clk(clk), .rst(rst), .req(req), .SW(sw), .RdData(rd_data), .RdEn(rd_en),
      .RdAddr(rd_addr), .RdPage(rd_page), .oWord(o_word), .oValid(o_valid), .iReady(rdy),
      .busy(busy), .frameDone(frame_done), .overrun(overrun));

   // RAM model: garbage when not read, so a mistimed capture shows up
   always @(posedge clk) ram_q <= rd_en ? {rd_page, rd_addr} : 12'hEEE;
   assign rd_data = ram_q;

   // Instance B: one-word frame, RAM_LAT=2
   logic          b_req = 1'b0, b_sw = 1'b0, b_rdy = 1'b0;
   logic [WW-1:0] b_rd_data, b_s1, b_s2, b_word;
   logic [AW-1:0] b_rd_addr;
   logic          b_rd_en, b_rd_page, b_valid, b_busy, b_done, b_over;

   orb_frame_reader #(.ADDR_W(AW), .WORD_W(WW), .FRAME_LEN(1), .RAM_LAT(2)) dut_b (
      .clk(clk), .rst(rst), .req(b_req), .SW(b_sw), .RdData(b_rd_data), .RdEn(b_rd_en),
      .RdAddr(b_rd_addr), .RdPage(b_rd_page), .oWord(b_word), .oValid(b_valid),
      .iReady(b_rdy), .busy(b_busy), .frameDone(b_done), .overrun(b_over));

   always @(posedge clk) begin
      b_s1 <= b_rd_en ? {b_rd_page, b_rd_addr} : 12'hEEE;
      b_s2 <= b_s1;
   end
   assign b_rd_data = b_s2;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Stream monitor for instance A; per-frame state restarts when busy rises
   logic exp_page = 1'b0;
   bit   mon_on = 1'b0;
   logic busy_prev = 1'b0;
   int   exp_rd = 0, exp_wd = 0, out_max = 0;
   int   n_done = 0, n_over = 0, n_start = 0;

   always @(negedge clk) begin
      if (rst) begin
         busy_prev = 1'b0;
      end else if (mon_on) begin
         if (busy && !busy_prev) begin
            n_start++;
            exp_rd  = 0;
            exp_wd  = 0;
            out_max = 0;
         end
         if (rd_en) begin
            check("rd_addr", 32'(rd_addr), exp_rd);
            check("rd_page", 32'(rd_page), 32'(exp_page));
            exp_rd++;
         end
         if (o_valid) check("o_word", 32'(o_word), 32'({exp_page, AW'(exp_wd)}));
         if (frame_done) begin
            check("done_idx", exp_wd, FL - 1);
            check("done_acc", 32'(o_valid & rdy), 1);
            n_done++;
         end
         if (overrun) n_over++;
         if (exp_rd - exp_wd > out_max) out_max = exp_rd - exp_wd;
         if (o_valid && rdy) exp_wd++;
         busy_prev = busy;
      end
   end

   int s_done, s_over, s_start;
   task automatic snap();
      s_done  = n_done;
      s_over  = n_over;
      s_start = n_start;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_rden"}, 32'(rd_en), 0);
      check({tag, "_addr"}, 32'(rd_addr), 0);
      check({tag, "_page"}, 32'(rd_page), 0);
      check({tag, "_word"}, 32'(o_word), 0);
      check({tag, "_valid"}, 32'(o_valid), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(frame_done), 0);
      check({tag, "_over"}, 32'(overrun), 0);
   endtask

   // Raise req (called at posedge+1) and check start latency; cycle 2 is req_rise
   task automatic start_frame(input bit hold);
      int f_busy = -1, f_rden = -1, f_val = -1;
      req = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (busy && f_busy < 0) f_busy = k;
         if (rd_en && f_rden < 0) f_rden = k;
         if (o_valid && f_val < 0) f_val = k;
         @(posedge clk);
         #1;
         if (k == 2 && !hold) req = 1'b0;
      end
      check("lat_busy", f_busy, 3);
      check("lat_rden", f_rden, 3);
      check("lat_valid", f_val, 5);
   endtask

   // Run the frame to idle with optional stall toggling, SW toggle, req glitch or abort
   task automatic run_frame(input bit toggle, input int sw_word, input int glitch_word,
                            input int abort_word, output bit aborted);
      bit sw_done = 0, gl_lo = 0, gl_hi = 0, fin = 0;
      int c = 0;
      aborted = 0;
      while (!fin && c < 6000) begin
         @(negedge clk);
         c++;
         if (!busy) begin
            fin = 1;
         end else begin
            @(posedge clk);
            #1;
            if (toggle) rdy = ~rdy;
            if (sw_word >= 0 && !sw_done && exp_wd >= sw_word) begin
               sw = ~sw;
               sw_done = 1;
            end
            if (glitch_word >= 0 && !gl_lo && exp_wd >= glitch_word) begin
               req = 1'b0;
               gl_lo = 1;
            end
            if (gl_lo && !gl_hi && exp_wd >= glitch_word + 4) begin
               req = 1'b1;
               gl_hi = 1;
            end
            if (abort_word >= 0 && exp_wd >= abort_word) begin
               rst = 1'b1;
               #1;
               aborted = 1;
               fin = 1;
            end
         end
      end
      if (!fin) check("frame_timeout", 32'(busy), 0);
      rdy = 1'b1;
      if (!aborted) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic frame_totals(input string tag, input int over_exp);
      check({tag, "_words"}, exp_wd, FL);
      check({tag, "_reads"}, exp_rd, FL);
      check({tag, "_ndone"}, n_done - s_done, 1);
      check({tag, "_nstart"}, n_start - s_start, 1);
      check({tag, "_nover"}, n_over - s_over, over_exp);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_bound"}, 32'(out_max <= 4), 1);
   endtask

   initial begin
      bit ab;
      int f_val, n_rd, n_dn, dn_k, n_hold;

      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      check("reset_b_busy", 32'(b_busy), 0);
      check("reset_b_valid", 32'(b_valid), 0);
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      mon_on = 1'b1;

      // 1: full frame, iReady=1, SW=0 -> page 1
      exp_page = 1'b1;
      snap();
      start_frame(0);
      run_frame(0, -1, -1, -1, ab);
      frame_totals("t1", 0);

      // 2: iReady toggling every cycle
      snap();
      start_frame(0);
      run_frame(1, -1, -1, -1, ab);
      frame_totals("t2", 0);

      // 3: SW toggles at word 100 -> page stays 1, one overrun
      snap();
      start_frame(0);
      run_frame(0, 100, -1, -1, ab);
      frame_totals("t3", 1);
      sw = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      sw = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("t3_idle_sw", n_over - s_over, 1);

      // 4: req held high with a mid-frame re-edge -> exactly one frame, page 0
      exp_page = 1'b0;
      snap();
      start_frame(1);
      run_frame(0, -1, 300, -1, ab);
      repeat (5000) @(posedge clk);
      #1;
      frame_totals("t4", 0);
      req = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // 5: reset at word 500, then a fresh frame from address 0
      snap();
      start_frame(0);
      run_frame(0, -1, -1, 500, ab);
      check("t5_aborted", 32'(ab), 1);
      check_zero("t5_rst");
      check("t5_no_done", n_done - s_done, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t5_discard", 32'(o_valid), 0);
      end
      @(posedge clk);
      #1;
      snap();
      start_frame(0);
      run_frame(0, -1, -1, -1, ab);
      frame_totals("t5", 0);

      // 6: instance B, one word, RAM_LAT=2, iReady low until cycle 12
      f_val = -1;
      n_rd = 0;
      n_dn = 0;
      dn_k = -1;
      n_hold = 0;
      b_req = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (b_rd_en) begin
            n_rd++;
            check("t6_addr", 32'(b_rd_addr), 0);
         end
         if (b_valid) begin
            if (f_val < 0) f_val = k;
            n_hold++;
            check("t6_word", 32'(b_word), 32'h800);
         end
         if (b_done) begin
            n_dn++;
            dn_k = k;
         end
         @(posedge clk);
         #1;
         if (k == 2) b_req = 1'b0;
         if (k == 11) b_rdy = 1'b1;
      end
      check("t6_nrd", n_rd, 1);
      check("t6_first_valid", f_val, 6);
      check("t6_valid_cycles", n_hold, 7);
      check("t6_done_cycle", dn_k, 12);
      check("t6_ndone", n_dn, 1);
      check("t6_busy", 32'(b_busy), 0);
      check("t6_over", 32'(b_over), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
